serial_adder: RTL

- Bit-serial adder that adds two WIDTH-bit operands plus a carry-in, one bit per clock, LSB first.
- Each bit is computed by a single instance of the team's existing full_adder cell. The carry is held in a flip-flop between cycles.
- Sits directly downstream of full_adder: it consumes that cell's sum/carry outputs every cycle and registers them.
- Valid/ready handshakes on input and output let it plug between other streaming stages.

---
 rtl/serial_adder.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: {carry_out, sum} = a + b + carry_in, one bit per clock, LSB first.
// One full_adder cell does the arithmetic; the running carry lives in carry_q.

// Single-bit full adder cell shared by the serial datapath.
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic sum_o,
  output logic carry_o
);

  // Plain combinational sum and carry.
  always_comb begin
    sum_o   = a_i ^ b_i ^ c_i;
    carry_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
  end

endmodule

// state | meaning
// IDLE  | waiting for operands, in_ready=1
// RUN   | shifting one bit per cycle through the full adder, WIDTH cycles
// OUT   | result presented, held until out_ready
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] sum_sh_q;
  logic [WIDTH-1:0] sum_sh_d;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             cout_q;
  logic [CW-1:0]    cnt_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;
  logic             fa_sum;
  logic             fa_carry;

  full_adder u_fa (
    .a_i     (a_sh_q[0]),
    .b_i     (b_sh_q[0]),
    .c_i     (carry_q),
    .sum_o   (fa_sum),
    .carry_o (fa_carry)
  );

  // New sum bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
  always_comb begin
    sum_sh_d = WIDTH'({fa_sum, sum_sh_q} >> 1);
  end

  // Sequencing FSM with registered handshake outputs; reset wins over any handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      sum_sh_q    <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            a_sh_q     <= a;
            b_sh_q     <= b;
            carry_q    <= carry_in;
            sum_sh_q   <= '0;
            cnt_q      <= '0;
            state_q    <= S_RUN;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        S_RUN: begin
          sum_sh_q <= sum_sh_d;
          carry_q  <= fa_carry;
          a_sh_q   <= a_sh_q >> 1;
          b_sh_q   <= b_sh_q >> 1;
          cnt_q    <= cnt_q + CW'(1);
          // Result is latched separately so it stays put through IDLE and the next RUN.
          if (cnt_q == LAST_BIT) begin
            sum_q       <= sum_sh_d;
            cout_q      <= fa_carry;
            state_q     <= S_OUT;
            out_valid_q <= 1'b1;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign sum       = sum_q;
  assign carry_out = cout_q;

endmodule
